// File: rtl/cla_accumulator_if.sv
// Stream bundle for cla_accumulator: job start, operand input, result output.
// master = operand source / result consumer, slave = accumulator.
interface cla_accumulator_if #(
    parameter int N     = 64,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [N-1:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     sum_out;
    logic             carry_out;
    logic             ovf;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, sum_out, carry_out, ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, sum_out, carry_out, ovf, busy
    );
endinterface

// File: rtl/cla_accumulator.sv
// Multi-operand accumulator: sums a job of len operands through a carry-lookahead
// adder in the feedback path and reports sticky unsigned/signed overflow.

// Carry-lookahead adder built from 4-bit lookahead groups; N must be a multiple of 4.
module cla #(
    parameter int N = 64
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        logic [3:0] g;
        logic [3:0] p;
        logic       c;
        w_c    = '0;
        w_c[0] = i_cin;
        for (int k = 0; k < N / 4; k++) begin
            g = w_g[4*k +: 4];
            p = w_p[4*k +: 4];
            c = w_c[4*k];
            w_c[4*k+1] = g[0] | (p[0] & c);
            w_c[4*k+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
            w_c[4*k+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                       | (p[2] & p[1] & p[0] & c);
            w_c[4*k+4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c);
        end
    end

    assign o_sum  = w_p ^ w_c[N-1:0];
    assign o_cout = w_c[N];
endmodule

// state   | meaning
// S_IDLE  | waiting for start; result of the previous job still presented
// S_ACCUM | accepting operands, one per cycle
// S_HOLD  | result valid, waiting for out_ready
module cla_accumulator #(
    parameter int N     = 64,
    parameter int CNT_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    cla_accumulator_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_acc;
    logic [CNT_W-1:0] r_remaining;
    logic             r_carry;
    logic             r_ovf;
    logic [N-1:0]     w_sum;
    logic             w_cout;
    logic             w_sovf;
    logic             w_clear;
    logic             w_acc_en;

    cla #(.N(N)) u_cla (
        .i_a    (r_acc),
        .i_b    (bus.in_data),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_sovf = (r_acc[N-1] == bus.in_data[N-1]) && (w_sum[N-1] != r_acc[N-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_acc_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = (bus.len != '0) ? S_ACCUM : S_HOLD;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    w_acc_en = 1'b1;
                    if (r_remaining == CNT_W'(1)) w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result registers are only cleared by an accepted start, so they persist after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_remaining <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_clear) begin
            r_acc       <= '0;
            r_remaining <= bus.len;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_acc_en) begin
            r_acc       <= w_sum;
            r_remaining <= r_remaining - CNT_W'(1);
            r_carry     <= r_carry | w_cout;
            r_ovf       <= r_ovf | w_sovf;
        end
    end

    assign bus.in_ready  = (r_state == S_ACCUM);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.sum_out   = r_acc;
    assign bus.carry_out = r_carry;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_cla_accumulator.sv
// Bench for cla_accumulator: an 8-bit instance checked every cycle against an
// arithmetic model, plus a 64-bit instance for the maximum-length job.
module tb_cla_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cla_accumulator_if #(.N(8),  .CNT_W(8)) b8 ();
    cla_accumulator_if #(.N(64), .CNT_W(8)) b64 ();

    cla_accumulator #(.N(8),  .CNT_W(8)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    cla_accumulator #(.N(64), .CNT_W(8)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    int n_chk  = 0;
    int n_pass = 0;
    int hs64   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model of the 8-bit instance: 0 = waiting, 1 = collecting, 2 = result pending.
    int         m_mode = 0;
    int         m_left = 0;
    logic [7:0] m_sum  = 8'h00;
    logic       m_c    = 1'b0;
    logic       m_v    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_left <= 0; m_sum <= 8'h00; m_c <= 1'b0; m_v <= 1'b0;
        end else begin
            case (m_mode)
                0: if (b8.start) begin
                    m_sum  <= 8'h00; m_c <= 1'b0; m_v <= 1'b0;
                    m_left <= int'(b8.len);
                    m_mode <= (b8.len != 0) ? 1 : 2;
                end
                1: if (b8.in_valid) begin
                    m_sum <= m_sum + b8.in_data;
                    if (int'(m_sum) + int'(b8.in_data) > 255) m_c <= 1'b1;
                    if (int'($signed(m_sum)) + int'($signed(b8.in_data)) > 127 ||
                        int'($signed(m_sum)) + int'($signed(b8.in_data)) < -128) m_v <= 1'b1;
                    m_left <= m_left - 1;
                    if (m_left == 1) m_mode <= 2;
                end
                default: if (b8.out_ready) m_mode <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cycle", {b8.in_ready, b8.out_valid, b8.busy, b8.carry_out, b8.ovf, b8.sum_out},
                     {m_mode == 1, m_mode == 2, m_mode != 0, m_c, m_v, m_sum});
        if (b64.in_valid && b64.in_ready) hs64++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] l);
        b8.start = 1'b1;
        b8.len   = l;
        tick();
        b8.start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d);
        b8.in_valid = 1'b1;
        b8.in_data  = d;
        tick();
        b8.in_valid = 1'b0;
        b8.in_data  = 8'hA5;
    endtask

    task automatic expect_result(input string nm, input logic [7:0] s, input logic c, input logic v);
        @(negedge clk);
        chk({nm, "_valid"}, b8.out_valid, 1'b1);
        chk({nm, "_sum"},   b8.sum_out, s);
        chk({nm, "_carry"}, b8.carry_out, c);
        chk({nm, "_ovf"},   b8.ovf, v);
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_idle"}, b8.busy, 1'b0);
        chk({nm, "_keep"}, b8.sum_out, s);
    endtask

    initial begin
        b8.start = 1'b0; b8.len = 8'd0; b8.in_valid = 1'b0; b8.in_data = 8'h00; b8.out_ready = 1'b0;
        b64.start = 1'b0; b64.len = 8'd0; b64.in_valid = 1'b0; b64.in_data = '0; b64.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {b8.in_ready, b8.out_valid, b8.busy, b8.carry_out, b8.ovf, b8.sum_out}, 13'h0);
        chk("rst_out64", {b64.out_valid, b64.busy, b64.sum_out}, 66'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // three operands back to back
        start_job(8'd3);
        feed(8'h10); feed(8'h20); feed(8'h30);
        expect_result("basic", 8'h60, 1'b0, 1'b0);

        // unsigned wrap, then signed overflow with flags cleared by the new start
        start_job(8'd2);
        feed(8'hFF); feed(8'h02);
        expect_result("uwrap", 8'h01, 1'b1, 1'b0);
        start_job(8'd2);
        @(negedge clk);
        chk("flags_cleared", {b8.carry_out, b8.ovf, b8.sum_out}, 10'h0);
        tick();
        feed(8'h7F); feed(8'h01);
        expect_result("sovf", 8'h80, 1'b0, 1'b1);

        // empty job
        start_job(8'd0);
        expect_result("len0", 8'h00, 1'b0, 1'b0);

        // input stalls, output backpressure, start during hold
        start_job(8'd3);
        feed(8'h11);
        b8.in_data = 8'h99;
        tick(); tick();
        feed(8'h22); feed(8'h33);
        b8.in_valid = 1'b1;
        b8.in_data  = 8'h44;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {b8.out_valid, b8.in_ready, b8.sum_out}, {2'b10, 8'h66});
            b8.start = (i == 2);
            b8.len   = 8'd5;
        end
        b8.in_valid  = 1'b0;
        b8.start     = 1'b1;
        b8.out_ready = 1'b1;
        tick();
        b8.start     = 1'b0;
        b8.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_start_ignored", {b8.busy, b8.out_valid, b8.sum_out}, {2'b00, 8'h66});

        // reset in the middle of a job
        tick();
        start_job(8'd3);
        feed(8'h40);
        rst_n = 1'b0;
        #1;
        chk("midrst", {b8.in_ready, b8.out_valid, b8.busy, b8.carry_out, b8.ovf, b8.sum_out}, 13'h0);
        tick();
        rst_n = 1'b1;
        tick();
        start_job(8'd1);
        feed(8'h05);
        expect_result("after_rst", 8'h05, 1'b0, 1'b0);

        // maximum-length job on the 64-bit instance; extra valids past the end must not be taken
        hs64 = 0;
        b64.start = 1'b1;
        b64.len   = 8'd255;
        tick();
        b64.start    = 1'b0;
        b64.in_valid = 1'b1;
        b64.in_data  = '1;
        repeat (258) tick();
        b64.in_valid = 1'b0;
        @(negedge clk);
        chk("max_valid", b64.out_valid, 1'b1);
        chk("max_sum",   b64.sum_out, 64'hFFFF_FFFF_FFFF_FF01);
        chk("max_carry", b64.carry_out, 1'b1);
        chk("max_ovf",   b64.ovf, 1'b0);
        chk("max_handshakes", 64'(hs64), 64'd255);
        b64.out_ready = 1'b1;
        tick();
        b64.out_ready = 1'b0;
        @(negedge clk);
        chk("max_idle", b64.busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
